// File: rtl/hpdmc_datapath_seq.sv
`default_nettype none
// ============================================================================
// Module   : hpdmc_datapath_seq
// Purpose  : Data-path sequencer for the 32-bit DDR memory controller.
//            Times every data beat of a read or write burst relative to the
//            command that started it. Drives the DDR I/O block (direction,
//            mo, dout), samples di, and tells the command scheduler when a
//            new read or write may be issued (read_safe / write_safe). The
//            safe windows keep bursts from colliding and leave one idle bus
//            cycle when the bus turns around from read to write.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CL     cycles from read command to first di beat sampled (CL >= WL)
//   WL     cycles from write command to first dout beat      (WL >= 1)
//   BURST  64-bit beats per burst                            (BURST >= 1)
// Ports
//   sys_clk     in   clock, all logic on the rising edge
//   sys_rst     in   synchronous active-high reset
//   read        in   read command strobe (one cycle)
//   write       in   write command strobe (one cycle)
//   read_safe   out  a read asserted this cycle is accepted
//   write_safe  out  a write asserted this cycle is accepted
//   write_data  in   write beat, sampled whenever write_next is 1
//   write_mask  in   byte mask for that beat (1 = masked)
//   write_next  out  requests the next write beat from the source
//   read_data   out  captured read beat
//   read_valid  out  read_data holds a valid beat
//   direction   out  1 = controller drives DQ/DQS (I/O output enable)
//   mo          out  DM bits to the I/O block
//   dout        out  DQ data to the I/O block ('do' is a reserved word)
//   di          in   DQ data from the I/O block
// ============================================================================
module hpdmc_datapath_seq #(
    parameter int CL    = 3,
    parameter int WL    = 1,
    parameter int BURST = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        read,
    input  logic        write,
    output logic        read_safe,
    output logic        write_safe,
    input  logic [63:0] write_data,
    input  logic [7:0]  write_mask,
    output logic        write_next,
    output logic [63:0] read_data,
    output logic        read_valid,
    output logic        direction,
    output logic [7:0]  mo,
    output logic [63:0] dout,
    input  logic [63:0] di
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    // History vectors: bit k means "a burst of this type was accepted k
    // cycles ago" (bit 0 is the acceptance in the current cycle).
    localparam int RLEN = CL + BURST;
    localparam int WLEN = WL + BURST;

    // Safe-window reload values (number of blocked cycles after t).
    localparam int SAME_LD  = BURST - 1;
    localparam int RD2WR_LD = CL + BURST - WL;
    localparam int WR2RD_T  = (BURST > (WL + BURST + 1 - CL)) ? BURST
                                                              : (WL + BURST + 1 - CL);
    localparam int WR2RD_LD = WR2RD_T - 1;

    localparam int MAX_A    = (SAME_LD > RD2WR_LD) ? SAME_LD : RD2WR_LD;
    localparam int MAX_LD   = (MAX_A > WR2RD_LD) ? MAX_A : WR2RD_LD;
    // +2 keeps the width at least one bit even when every load is zero.
    localparam int CW       = $clog2(MAX_LD + 2);

    localparam logic [CW-1:0] SAME_LD_V  = CW'(SAME_LD);
    localparam logic [CW-1:0] RD2WR_LD_V = CW'(RD2WR_LD);
    localparam logic [CW-1:0] WR2RD_LD_V = CW'(WR2RD_LD);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    // One bit per beat, shifted to the offset where the window starts.
    localparam logic [63:0]     BEATS   = (64'd1 << BURST) - 64'd1;
    localparam logic [RLEN-1:0] RD_WIN  = RLEN'(BEATS << CL);
    localparam logic [WLEN-1:0] WN_WIN  = WLEN'(BEATS << (WL - 1));
    localparam logic [WLEN-1:0] DIR_WIN = WLEN'(BEATS << WL);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [RLEN-2:0] rd_hist_q,    rd_hist_d;
    logic [WLEN-2:0] wr_hist_q,    wr_hist_d;
    logic [CW-1:0]   busy_cnt_q,   busy_cnt_d;
    logic [CW-1:0]   rd2wr_cnt_q,  rd2wr_cnt_d;
    logic [CW-1:0]   wr2rd_cnt_q,  wr2rd_cnt_d;
    logic [63:0]     read_data_q,  read_data_d;
    logic            read_valid_q, read_valid_d;
    logic [63:0]     dout_q,       dout_d;
    logic [7:0]      mo_q,         mo_d;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic            rd_acc;
    logic            wr_acc;
    logic [RLEN-1:0] rd_vec;
    logic [WLEN-1:0] wr_vec;
    logic            rd_sample;

    // Safe flags come only from the counters, never from the strobes.
    assign read_safe  = (busy_cnt_q == '0) && (wr2rd_cnt_q == '0);
    assign write_safe = (busy_cnt_q == '0) && (rd2wr_cnt_q == '0);

    // A read wins over a simultaneous write, even when the read itself is
    // refused. Nothing is accepted while reset is asserted.
    assign rd_acc = read & read_safe & ~sys_rst;
    assign wr_acc = write & write_safe & ~read & ~sys_rst;

    assign rd_vec = {rd_hist_q, rd_acc};
    assign wr_vec = {wr_hist_q, wr_acc};

    // Overlapping same-type bursts simply OR into the shared history.
    assign rd_sample  = |(rd_vec & RD_WIN);
    assign write_next = |(wr_vec & WN_WIN);
    // The DIR window starts at k = WL >= 1, so direction depends on
    // registered history only and cannot glitch with the write strobe.
    assign direction  = |(wr_vec & DIR_WIN);

    always_comb begin
        rd_hist_d    = rd_vec[RLEN-2:0];
        wr_hist_d    = wr_vec[WLEN-2:0];
        busy_cnt_d   = busy_cnt_q;
        rd2wr_cnt_d  = rd2wr_cnt_q;
        wr2rd_cnt_d  = wr2rd_cnt_q;
        read_data_d  = read_data_q;
        read_valid_d = rd_sample;
        dout_d       = dout_q;
        mo_d         = 8'hff;

        // Same-type spacing: both directions blocked for BURST-1 cycles.
        if (rd_acc || wr_acc) begin
            busy_cnt_d = SAME_LD_V;
        end else if (busy_cnt_q != '0) begin
            busy_cnt_d = busy_cnt_q - CNT_ONE;
        end

        // Read-to-write turnaround: keeps the write data clear of the last
        // read beat by one idle bus cycle.
        if (rd_acc) begin
            rd2wr_cnt_d = RD2WR_LD_V;
        end else if (rd2wr_cnt_q != '0) begin
            rd2wr_cnt_d = rd2wr_cnt_q - CNT_ONE;
        end

        // Write-to-read spacing.
        if (wr_acc) begin
            wr2rd_cnt_d = WR2RD_LD_V;
        end else if (wr2rd_cnt_q != '0) begin
            wr2rd_cnt_d = wr2rd_cnt_q - CNT_ONE;
        end

        // Read capture: registered one cycle after the di sample point.
        if (rd_sample) begin
            read_data_d = di;
        end

        // Write beat fetched in cycle c-1 is presented in data cycle c.
        // DM idles at all-masked; DQ keeps its last value.
        if (write_next) begin
            dout_d = write_data;
            mo_d   = write_mask;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rd_hist_q    <= '0;
            wr_hist_q    <= '0;
            busy_cnt_q   <= '0;
            rd2wr_cnt_q  <= '0;
            wr2rd_cnt_q  <= '0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            dout_q       <= '0;
            mo_q         <= 8'hff;
        end else begin
            rd_hist_q    <= rd_hist_d;
            wr_hist_q    <= wr_hist_d;
            busy_cnt_q   <= busy_cnt_d;
            rd2wr_cnt_q  <= rd2wr_cnt_d;
            wr2rd_cnt_q  <= wr2rd_cnt_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            dout_q       <= dout_d;
            mo_q         <= mo_d;
        end
    end

    assign read_data  = read_data_q;
    assign read_valid = read_valid_q;
    assign dout       = dout_q;
    assign mo         = mo_q;

endmodule
`default_nettype wire

// File: tb/tb_hpdmc_datapath_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_hpdmc_datapath_seq
// Purpose  : Directed self-checking bench for hpdmc_datapath_seq with the
//            default parameters (CL=3, WL=1, BURST=4). Cycle 0 of each
//            step is the cycle in which the first command strobe is driven.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hpdmc_datapath_seq;

    logic        sys_clk;
    logic        sys_rst;
    logic        read;
    logic        write;
    logic        read_safe;
    logic        write_safe;
    logic [63:0] write_data;
    logic [7:0]  write_mask;
    logic        write_next;
    logic [63:0] read_data;
    logic        read_valid;
    logic        direction;
    logic [7:0]  mo;
    logic [63:0] dout;
    logic [63:0] di;

    int tests = 0;
    int fails = 0;

    logic [63:0] wv [4];

    hpdmc_datapath_seq #(.CL(3), .WL(1), .BURST(4)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .read       (read),
        .write      (write),
        .read_safe  (read_safe),
        .write_safe (write_safe),
        .write_data (write_data),
        .write_mask (write_mask),
        .write_next (write_next),
        .read_data  (read_data),
        .read_valid (read_valid),
        .direction  (direction),
        .mo         (mo),
        .dout       (dout),
        .di         (di)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs set afterwards
    // belong to the new cycle.
    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drive_idle();
        sys_rst    = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        write_data = 64'h0;
        write_mask = 8'h00;
        di         = 64'h0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            drive_idle();
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " direction"},  direction,  1'b0);
        chk({tag, " mo"},         mo,         8'hff);
        chk({tag, " dout"},       dout,       64'h0);
        chk({tag, " write_next"}, write_next, 1'b0);
        chk({tag, " read_valid"}, read_valid, 1'b0);
        chk({tag, " read_data"},  read_data,  64'h0);
        chk({tag, " read_safe"},  read_safe,  1'b1);
        chk({tag, " write_safe"}, write_safe, 1'b1);
    endtask

    initial begin
        wv[0] = 64'h0123_4567_89ab_cdef;
        wv[1] = 64'hfeed_face_cafe_beef;
        wv[2] = 64'h1111_2222_3333_4444;
        wv[3] = 64'ha5a5_5a5a_0f0f_f0f0;

        drive_idle();
        sys_rst = 1'b1;
        repeat (3) step();
        sys_rst = 1'b0;
        #1;
        chk_reset_outputs("reset");

        // ---- Read, defaults ------------------------------------------
        idle(2);
        for (int c = 0; c <= 8; c++) begin
            step();
            read = (c == 0);
            di   = (c >= 3 && c <= 6) ? 64'(c - 2) : 64'hbad0_0000 + 64'(c);
            #1;
            chk($sformatf("rd valid c%0d", c), read_valid, (c >= 4 && c <= 7));
            if (c >= 4 && c <= 7)
                chk($sformatf("rd data c%0d", c), read_data, 64'(c - 3));
            if (c == 8)
                chk("rd data hold c8", read_data, 64'd4);
            if (c <= 4)
                chk($sformatf("rd read_safe c%0d", c), read_safe, !(c >= 1 && c <= 3));
            if (c <= 7)
                chk($sformatf("rd write_safe c%0d", c), write_safe, !(c >= 1 && c <= 6));
            chk($sformatf("rd direction c%0d", c), direction, 1'b0);
        end
        drive_idle();

        // ---- Write, defaults -----------------------------------------
        idle(10);
        for (int c = 0; c <= 5; c++) begin
            step();
            write = (c == 0);
            if (c <= 3) begin
                write_data = wv[c];
                write_mask = (c == 2) ? 8'h0f : 8'h00;
            end else begin
                write_data = 64'hdead_dead_dead_dead;
                write_mask = 8'h55;
            end
            #1;
            chk($sformatf("wr write_next c%0d", c), write_next, (c <= 3));
            chk($sformatf("wr direction c%0d", c), direction, (c >= 1 && c <= 4));
            if (c >= 1)
                chk($sformatf("wr dout c%0d", c), dout, wv[(c >= 5) ? 3 : c - 1]);
            chk($sformatf("wr mo c%0d", c), mo,
                (c == 3) ? 8'h0f : (c >= 1 && c <= 4) ? 8'h00 : 8'hff);
            if (c >= 1 && c <= 4)
                chk($sformatf("wr read_safe c%0d", c), read_safe, (c == 4));
        end
        drive_idle();

        // ---- Read then write at 7 (accepted) -------------------------
        idle(10);
        for (int c = 0; c <= 9; c++) begin
            step();
            read       = (c == 0);
            write      = (c == 7);
            write_data = 64'h77 + 64'(c);
            #1;
            if (c == 7)
                chk("rw write_safe c7", write_safe, 1'b1);
            chk($sformatf("rw write_next c%0d", c), write_next, (c >= 7));
            chk($sformatf("rw direction c%0d", c), direction, (c >= 8));
        end
        drive_idle();

        // ---- Read then write at 6 (refused) --------------------------
        idle(12);
        for (int c = 0; c <= 12; c++) begin
            step();
            read  = (c == 0);
            write = (c == 6);
            #1;
            if (c == 6)
                chk("rw6 write_safe c6", write_safe, 1'b0);
            if (c >= 6) begin
                chk($sformatf("rw6 write_next c%0d", c), write_next, 1'b0);
                chk($sformatf("rw6 direction c%0d", c), direction, 1'b0);
                chk($sformatf("rw6 mo c%0d", c), mo, 8'hff);
            end
        end
        drive_idle();

        // ---- Write at 0, read at 4 -----------------------------------
        idle(12);
        for (int c = 0; c <= 12; c++) begin
            step();
            write      = (c == 0);
            read       = (c == 4);
            write_data = 64'h55 + 64'(c);
            di         = 64'h200 + 64'(c);
            #1;
            if (c == 4)
                chk("wr-rd read_safe c4", read_safe, 1'b1);
            chk($sformatf("wr-rd valid c%0d", c), read_valid, (c >= 8 && c <= 11));
            if (c >= 8 && c <= 11)
                chk($sformatf("wr-rd data c%0d", c), read_data, 64'h200 + 64'(c - 1));
            chk($sformatf("wr-rd direction c%0d", c), direction, (c >= 1 && c <= 4));
        end
        drive_idle();

        // ---- Back-to-back reads at 0 and 4 ---------------------------
        idle(12);
        for (int c = 0; c <= 12; c++) begin
            step();
            read = (c == 0 || c == 4);
            di   = 64'h300 + 64'(c);
            #1;
            if (c == 4)
                chk("b2b read_safe c4", read_safe, 1'b1);
            chk($sformatf("b2b valid c%0d", c), read_valid, (c >= 4 && c <= 11));
            if (c >= 4 && c <= 11)
                chk($sformatf("b2b data c%0d", c), read_data, 64'h300 + 64'(c - 1));
        end
        drive_idle();

        // ---- Simultaneous read and write -----------------------------
        idle(12);
        for (int c = 0; c <= 9; c++) begin
            step();
            read  = (c == 0);
            write = (c == 0);
            di    = 64'h400 + 64'(c);
            #1;
            chk($sformatf("sim write_next c%0d", c), write_next, 1'b0);
            chk($sformatf("sim direction c%0d", c), direction, 1'b0);
            chk($sformatf("sim valid c%0d", c), read_valid, (c >= 4 && c <= 7));
            if (c >= 4 && c <= 7)
                chk($sformatf("sim data c%0d", c), read_data, 64'h400 + 64'(c - 1));
        end
        drive_idle();

        // ---- Reset in the middle of a read ---------------------------
        idle(12);
        for (int c = 0; c <= 9; c++) begin
            step();
            read    = (c == 0);
            sys_rst = (c == 2);
            di      = 64'h500 + 64'(c);
            #1;
            if (c >= 3)
                chk_reset_outputs($sformatf("rst-rd c%0d", c));
        end
        drive_idle();

        // ---- Reset in the middle of a write --------------------------
        idle(4);
        for (int c = 0; c <= 8; c++) begin
            step();
            write   = (c == 0);
            sys_rst = (c == 2);
            if (c <= 3) begin
                write_data = wv[c];
                write_mask = 8'h00;
            end else begin
                write_data = 64'h0;
            end
            #1;
            if (c == 2)
                chk("rst-wr dout c2", dout, wv[1]);
            if (c >= 3)
                chk_reset_outputs($sformatf("rst-wr c%0d", c));
        end
        drive_idle();

        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
